// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
// Divide support is compiled in only when HILO_DIV_EN is defined.
package hilo_pkg;

    localparam int          ITER_DEFAULT = 32;
    localparam logic [31:0] LO_DIV_ZERO  = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_MADD  = 4'd3,
        OP_MSUB  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_DIV   = 4'd7,
        OP_DIVU  = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/hilo_iter_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// The divide path exists only when HILO_DIV_EN is defined.
module hilo_iter_step (
    input  logic        mode_div,
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    output logic [63:0] acc_o
);

    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
`ifdef HILO_DIV_EN
    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;
    logic [63:0] div_next_s;
`endif

    // Multiply: acc = {partial product, remaining multiplier bits}
    always_comb begin
        if (acc_i[0]) begin
            mul_sum_s = {1'b0, acc_i[63:32]} + {1'b0, opnd_i};
        end else begin
            mul_sum_s = {1'b0, acc_i[63:32]};
        end
        mul_next_s = {mul_sum_s, acc_i[31:1]};
    end

`ifdef HILO_DIV_EN
    // Divide: acc = {remainder, dividend bits shifting into quotient}
    always_comb begin
        div_shift_s = {acc_i[63:32], acc_i[31]};
        div_diff_s  = div_shift_s - {1'b0, opnd_i};
        if (!div_diff_s[32]) begin
            div_next_s = {div_diff_s[31:0], acc_i[30:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[31:0], acc_i[30:0], 1'b0};
        end
    end

    // Mode select
    always_comb begin
        if (mode_div) begin
            acc_o = div_next_s;
        end else begin
            acc_o = mul_next_s;
        end
    end
`else
    // Mode select (divide absent: hold)
    always_comb begin
        if (mode_div) begin
            acc_o = acc_i;
        end else begin
            acc_o = mul_next_s;
        end
    end
`endif

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: sequences iterative MULT/MULTU/MADD/MSUB (and DIV/DIVU when
// HILO_DIV_EN is defined), handles MTHI/MTLO and stalls the pipeline.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        read_req,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(ITER + 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        opnd_q, opnd_d;
    logic [63:0]        acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               mul_signed_s;
    logic               step_div_s;
    logic [63:0]        step_acc_s;
    logic [63:0]        prod_fix_s;
`ifdef HILO_DIV_EN
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic               div_signed_s;
    logic [31:0]        quo_fix_s;
    logic [31:0]        rem_fix_s;

    assign step_div_s = (state_q == S_DIV);
`else
    assign step_div_s = 1'b0;
`endif

    hilo_iter_step u_step (
        .mode_div (step_div_s),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc_s)
    );

    // Sign fix-up of the unsigned iteration result
    always_comb begin
        mul_signed_s = (op_e'(op) != OP_MULTU);
        if (neg_q) begin
            prod_fix_s = 64'd0 - acc_q;
        end else begin
            prod_fix_s = acc_q;
        end
`ifdef HILO_DIV_EN
        div_signed_s = (op_e'(op) == OP_DIV);
        if (neg_q) begin
            quo_fix_s = 32'd0 - acc_q[31:0];
        end else begin
            quo_fix_s = acc_q[31:0];
        end
        if (rneg_q) begin
            rem_fix_s = 32'd0 - acc_q[63:32];
        end else begin
            rem_fix_s = acc_q[63:32];
        end
`endif
    end

    // Next-state, datapath and commit logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef HILO_DIV_EN
        rneg_d  = rneg_q;
        dz_d    = dz_q;
`endif
        if (flush) begin
            // Abort wins over commit and over a new request
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op_e'(op))
                            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                                op_d    = op_e'(op);
                                opnd_d  = mul_signed_s ? abs32(a) : a;
                                acc_d   = {32'd0, (mul_signed_s ? abs32(b) : b)};
                                neg_d   = mul_signed_s & (a[31] ^ b[31]);
                                cnt_d   = {CNT_W{1'b0}};
                                busy_d  = 1'b1;
                                state_d = S_MUL;
                            end
`ifdef HILO_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                op_d    = op_e'(op);
                                opnd_d  = div_signed_s ? abs32(b) : b;
                                acc_d   = {32'd0, (div_signed_s ? abs32(a) : a)};
                                neg_d   = div_signed_s & (a[31] ^ b[31]);
                                rneg_d  = div_signed_s & a[31];
                                dz_d    = (b == 32'd0);
                                cnt_d   = {CNT_W{1'b0}};
                                busy_d  = 1'b1;
                                state_d = S_DIV;
                            end
`endif
                            OP_MTHI: begin
                                hi_d   = a;
                                done_d = 1'b1;
                            end
                            OP_MTLO: begin
                                lo_d   = a;
                                done_d = 1'b1;
                            end
                            default: begin
                                state_d = S_IDLE;
                            end
                        endcase
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MUL: begin
                    acc_d = step_acc_s;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
`ifdef HILO_DIV_EN
                S_DIV: begin
                    acc_d = step_acc_s;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
`endif
                S_FIX: begin
                    case (op_q)
                        OP_MULT, OP_MULTU: begin
                            {hi_d, lo_d} = prod_fix_s;
                        end
                        OP_MADD: begin
                            {hi_d, lo_d} = {hi_q, lo_q} + prod_fix_s;
                        end
                        OP_MSUB: begin
                            {hi_d, lo_d} = {hi_q, lo_q} - prod_fix_s;
                        end
`ifdef HILO_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            // Zero divisor: remainder fix-up already yields A
                            hi_d = rem_fix_s;
                            lo_d = dz_q ? LO_DIV_ZERO : quo_fix_s;
                        end
`endif
                        default: begin
                            hi_d = hi_q;
                        end
                    endcase
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= {CNT_W{1'b0}};
            opnd_q  <= 32'd0;
            acc_q   <= 64'd0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef HILO_DIV_EN
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef HILO_DIV_EN
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = busy_q & (start | read_req);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed scoreboard bench for hilo_muldiv_ctrl (works with or without HILO_DIV_EN).
module tb_hilo_muldiv_ctrl;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        read_req = 1'b0;
    logic        flush = 1'b0;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb_q[$];
    logic [63:0] model_hilo = 64'd0;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .read_req(read_req), .flush(flush), .busy(busy), .stall(stall),
        .done(done), .hi(hi), .lo(lo)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input op_e o, input logic [31:0] va,
                                          input logic [31:0] vb, input logic [63:0] cur);
        logic signed [63:0] sa, sb;
        logic [31:0] q, r;
        sa = {{32{va[31]}}, va};
        sb = {{32{vb[31]}}, vb};
        case (o)
            OP_MULT:  return sa * sb;
            OP_MULTU: return {32'd0, va} * {32'd0, vb};
            OP_MADD:  return cur + (sa * sb);
            OP_MSUB:  return cur - (sa * sb);
            OP_MTHI:  return {va, cur[31:0]};
            OP_MTLO:  return {cur[63:32], va};
            OP_DIV: begin
                if (vb == 32'd0) return {va, 32'hFFFF_FFFF};
                if (va == 32'h8000_0000 && vb == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(va) / $signed(vb);
                r = $signed(va) % $signed(vb);
                return {r, q};
            end
            OP_DIVU: begin
                if (vb == 32'd0) return {va, 32'hFFFF_FFFF};
                return {va % vb, va / vb};
            end
            default:  return cur;
        endcase
    endfunction

    // Issue one accepted op, wait (bounded) for Done, check latency and result.
    task automatic run_op(input string tag, input op_e o, input logic [31:0] va,
                          input logic [31:0] vb, input int lat);
        int n;
        logic [63:0] e;
        model_hilo = model(o, va, vb, model_hilo);
        sb_q.push_back(model_hilo);
        start = 1'b1; op = o; a = va; b = vb;
        tick;
        start = 1'b0; a = $urandom; b = $urandom;
        if (lat > 1) check({tag, "_busy1"}, 64'(busy), 64'd1);
        n = 1;
        while (!done && n < 100) begin
            tick;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_hilo"}, {hi, lo}, e);
        end
    endtask

    // Present an op that must be ignored; Busy/Done stay low, HI/LO unchanged.
    task automatic ignored_op(input string tag, input op_e o);
        int seen;
        start = 1'b1; op = o; a = 32'hFFFF_FFF9; b = 32'd2;
        tick;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy || done) seen++;
            tick;
        end
        check({tag, "_no_busy_done"}, 64'(seen), 64'd0);
        check({tag, "_hilo_kept"}, {hi, lo}, model_hilo);
    endtask

    initial begin
        int dcount;
        op_e rop;

        // Reset state
        tick; tick;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        tick;

        // Main function
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 34);
        check("mult_neg_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 34);
        check("multu_const", {hi, lo}, {32'h0000_0002, 32'hFFFF_FFFA});
        run_op("mthi", OP_MTHI, 32'd5, 32'd0, 1);
        run_op("mtlo", OP_MTLO, 32'd7, 32'd0, 1);
        run_op("madd", OP_MADD, 32'd2, 32'd3, 34);
        check("madd_const", {hi, lo}, {32'd5, 32'd13});
        run_op("msub", OP_MSUB, 32'd1, 32'd8, 34);
        check("msub_const", {hi, lo}, {32'd5, 32'd5});
        run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 34);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("msub_wrap", OP_MSUB, 32'h8000_0000, 32'h7FFF_FFFF, 34);
        for (int i = 0; i < 4; i++) begin
            rop = op_e'(4'($urandom_range(1, 4)));
            run_op("rand_mul", rop, $urandom, $urandom, 34);
        end

        // Stall on ReadReq/Start while busy, then flush
        check("idle_stall", 64'(stall), 64'd0);
        start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
        tick;
        start = 1'b0;
        repeat (4) tick;
        read_req = 1'b1; #1;
        check("stall_read", 64'(stall), 64'd1);
        read_req = 1'b0;
        tick;
        start = 1'b1; op = OP_MTHI; a = 32'd99; #1;
        check("stall_start", 64'(stall), 64'd1);
        tick;
        start = 1'b0;
        check("start_not_taken", {hi, lo}, model_hilo);
        repeat (3) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcount++;
            tick;
        end
        check("flush_no_done", 64'(dcount), 64'd0);
        check("flush_hilo", {hi, lo}, model_hilo);

        // Asynchronous reset mid-operation
        start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5;
        tick;
        start = 1'b0;
        repeat (19) tick;
        rst_n = 1'b0; #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hilo", {hi, lo}, 64'd0);
        model_hilo = 64'd0;
        tick;
        rst_n = 1'b1;
        tick;
        run_op("post_rst_mult", OP_MULT, 32'd7, 32'hFFFF_FFFA, 34);

        // Ignored ops and divide
        ignored_op("nop", OP_NOP);
`ifdef HILO_DIV_EN
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34);
        check("div_neg_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 34);
        check("divu_zero_const", {hi, lo}, {32'd7, 32'hFFFF_FFFF});
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34);
        run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 34);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd10, 34);
        run_op("div_mix", OP_DIV, 32'd100, 32'hFFFF_FFF9, 34);
`else
        ignored_op("div_off", OP_DIV);
        ignored_op("divu_off", OP_DIVU);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
